// File: rtl/wb_gpio_seq_if.sv
// wb_gpio_seq_if: 8-bit Wishbone link between the sequencer and a GPIO core
interface wb_gpio_seq_if;
    logic       cyc;
    logic       stb;
    logic       we;
    logic       adr;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack;
    logic       err;
    modport master (output cyc, stb, we, adr, dat_o, input dat_i, ack, err);
    modport slave  (input cyc, stb, we, adr, dat_o, output dat_i, ack, err);
endinterface

// File: rtl/wb_gpio_seq.sv
// wb_gpio_seq: Wishbone master that steps a pattern table out to a GPIO core and samples its input
module wb_gpio_seq #(
    parameter int ACK_TIMEOUT = 16,
    parameter int PAT_DEPTH   = 4,
    localparam int AW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1,
    localparam int TW = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [7:0]    i_dir,
    input  logic [15:0]   i_period,
    input  logic [AW-1:0] i_len,
    input  logic          i_pat_we,
    input  logic [AW-1:0] i_pat_addr,
    input  logic [7:0]    i_pat_data,
    wb_gpio_seq_if.master wb,
    output logic          o_busy,
    output logic [7:0]    o_in_data,
    output logic          o_change,
    output logic          o_err
);
    typedef enum logic [2:0] {IDLE, DIR, OUT, IN, WAIT} state_t;
    state_t        state;
    logic [7:0]    pat [PAT_DEPTH];
    logic [AW-1:0] idx, len_q, idx_nx;
    logic [15:0]   per_q, wcnt;
    logic [TW-1:0] tcnt;
    logic          stop_q, first_q, fail, term;
    // len_q of 0 wraps len_q-1 to the last entry, so it naturally means the full table
    assign idx_nx = (idx == len_q - AW'(1)) ? '0 : idx + AW'(1);
    assign fail   = wb.err || (!wb.ack && tcnt == TW'(ACK_TIMEOUT - 1));
    assign term   = wb.stb && (wb.ack || fail);
    assign o_busy = state != IDLE;
    // pattern table write port, usable in every state
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            for (int i = 0; i < PAT_DEPTH; i++) pat[i] <= '0;
        else if (i_pat_we)
            pat[i_pat_addr] <= i_pat_data;
    end
    // sequencer: each transaction is a setup cycle followed by strobe cycles until termination
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            wb.cyc    <= 1'b0;
            wb.stb    <= 1'b0;
            wb.we     <= 1'b0;
            wb.adr    <= 1'b0;
            wb.dat_o  <= '0;
            idx       <= '0;
            len_q     <= '0;
            per_q     <= '0;
            wcnt      <= '0;
            tcnt      <= '0;
            stop_q    <= 1'b0;
            first_q   <= 1'b0;
            o_in_data <= '0;
            o_change  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_change <= 1'b0;
            case (state)
                IDLE: if (i_start && !i_stop) begin
                    state    <= DIR;
                    wb.adr   <= 1'b1;
                    wb.we    <= 1'b1;
                    wb.dat_o <= i_dir;
                    per_q    <= (i_period == '0) ? 16'd1 : i_period;
                    len_q    <= i_len;
                    idx      <= '0;
                    o_err    <= 1'b0;
                    first_q  <= 1'b1;
                    stop_q   <= 1'b0;
                end
                WAIT: if (i_stop) begin
                    state <= IDLE;
                end else if (wcnt == per_q - 16'd1) begin
                    state    <= OUT;
                    idx      <= idx_nx;
                    wb.adr   <= 1'b0;
                    wb.we    <= 1'b1;
                    wb.dat_o <= pat[idx_nx];
                end else begin
                    wcnt <= wcnt + 16'd1;
                end
                default: begin
                    stop_q <= stop_q | i_stop;
                    if (!wb.stb) begin
                        wb.cyc <= 1'b1;
                        wb.stb <= 1'b1;
                        tcnt   <= '0;
                    end else if (term) begin
                        wb.cyc <= 1'b0;
                        wb.stb <= 1'b0;
                        if (fail) begin
                            o_err <= 1'b1;
                            state <= IDLE;
                        end else begin
                            if (state == IN) begin
                                o_in_data <= wb.dat_i;
                                o_change  <= !first_q && (wb.dat_i != o_in_data);
                                first_q   <= 1'b0;
                            end
                            if (stop_q || i_stop) begin
                                state <= IDLE;
                            end else if (state == DIR) begin
                                state    <= OUT;
                                wb.adr   <= 1'b0;
                                wb.dat_o <= pat[idx];
                            end else if (state == OUT) begin
                                state <= IN;
                                wb.we <= 1'b0;
                            end else begin
                                state <= WAIT;
                                wcnt  <= '0;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
            endcase
        end
    end
endmodule
